// File: rtl/fifo_dma_req_bridge.sv
// Two-channel bridge: FIFO rx/tx DMA request levels -> HPS f2h_dma_req0/1 4-phase handshake, with post-ack holdoff.
// Optional per-channel handshake counters are built when FIFO_DMA_REQ_BRIDGE_STATS_EN is defined.
module fifo_dma_req_bridge #(
   parameter int unsigned HOLDOFF_CYCLES = 4,
   parameter int unsigned CNT_W          = 16
) (
   input  logic             clk_clk,
   input  logic             reset_reset_n,
   input  logic             rx_pri_single,
   input  logic             rx_pri_burst,
   output logic             rx_pri_ack,
   input  logic             tx_pri_single,
   input  logic             tx_pri_burst,
   output logic             tx_pri_ack,
   output logic             f2h_dma_req0_dma_req,
   output logic             f2h_dma_req0_dma_single,
   input  logic             f2h_dma_req0_dma_ack,
   output logic             f2h_dma_req1_dma_req,
   output logic             f2h_dma_req1_dma_single,
   input  logic             f2h_dma_req1_dma_ack
`ifdef FIFO_DMA_REQ_BRIDGE_STATS_EN
   ,
   output logic [CNT_W-1:0] rx_xfer_cnt,
   output logic [CNT_W-1:0] tx_xfer_cnt
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_WAIT_ACK_LOW,
      ST_HOLDOFF
   } state_t;

   typedef enum logic {
      REQ_SINGLE,
      REQ_BURST
   } req_type_t;

   // Counter is loaded with HOLDOFF_CYCLES-1 so the HOLDOFF state lasts exactly HOLDOFF_CYCLES cycles.
   localparam logic [7:0] HOLD_LOAD = (HOLDOFF_CYCLES == 0) ? 8'd0 : 8'(HOLDOFF_CYCLES - 1);

   logic [1:0] pri_single;
   logic [1:0] pri_burst;
   logic [1:0] dma_ack;

   assign pri_single = {tx_pri_single, rx_pri_single};
   assign pri_burst  = {tx_pri_burst,  rx_pri_burst};
   assign dma_ack    = {f2h_dma_req1_dma_ack, f2h_dma_req0_dma_ack};

   for (genvar ch = 0; ch < 2; ch++) begin : g_ch
      state_t    state, state_nxt;
      req_type_t req_type, req_type_nxt;
      logic [7:0] hold_cnt, hold_cnt_nxt;
      logic      pri_ack_nxt;
      logic      dma_req_q, dma_single_q, pri_ack_q;

      always_comb begin
         // NOTE: every signal written here gets a default first, so no path can infer a latch.
         state_nxt    = state;
         req_type_nxt = req_type;
         hold_cnt_nxt = hold_cnt;
         pri_ack_nxt  = 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (pri_burst[ch]) begin
                  state_nxt    = ST_REQ;
                  req_type_nxt = REQ_BURST;
               end else if (pri_single[ch]) begin
                  state_nxt    = ST_REQ;
                  req_type_nxt = REQ_SINGLE;
               end
            end
            ST_REQ: begin
               if (dma_ack[ch]) begin
                  state_nxt   = ST_WAIT_ACK_LOW;
                  pri_ack_nxt = 1'b1;
               end
            end
            ST_WAIT_ACK_LOW: begin
               if (!dma_ack[ch]) begin
                  if (HOLDOFF_CYCLES == 0) begin
                     state_nxt = ST_IDLE;
                  end else begin
                     state_nxt    = ST_HOLDOFF;
                     hold_cnt_nxt = HOLD_LOAD;
                  end
               end
            end
            ST_HOLDOFF: begin
               if (hold_cnt == 8'd0) begin
                  state_nxt = ST_IDLE;
               end else begin
                  hold_cnt_nxt = hold_cnt - 8'd1;
               end
            end
            default: state_nxt = ST_IDLE;
         endcase
      end

      // Outputs are registered from the next state so they align with the state they describe.
      always_ff @(posedge clk_clk) begin
         // NOTE: reset is sampled on the clock edge only; an asynchronous term here would change the timing contract.
         if (!reset_reset_n) begin
            state        <= ST_IDLE;
            req_type     <= REQ_SINGLE;
            hold_cnt     <= 8'd0;
            dma_req_q    <= 1'b0;
            dma_single_q <= 1'b0;
            pri_ack_q    <= 1'b0;
         end else begin
            // NOTE: sequential state uses non-blocking assignment so every register sees pre-edge values.
            state        <= state_nxt;
            req_type     <= req_type_nxt;
            hold_cnt     <= hold_cnt_nxt;
            dma_req_q    <= (state_nxt == ST_REQ) && (req_type_nxt == REQ_BURST);
            dma_single_q <= (state_nxt == ST_REQ) && (req_type_nxt == REQ_SINGLE);
            pri_ack_q    <= pri_ack_nxt;
         end
      end

`ifdef FIFO_DMA_REQ_BRIDGE_STATS_EN
      logic [CNT_W-1:0] xfer_cnt;

      always_ff @(posedge clk_clk) begin
         if (!reset_reset_n) begin
            xfer_cnt <= '0;
         end else if (pri_ack_nxt && (xfer_cnt != {CNT_W{1'b1}})) begin
            xfer_cnt <= xfer_cnt + 1'b1;
         end
      end
`endif
   end : g_ch

   assign rx_pri_ack              = g_ch[0].pri_ack_q;
   assign tx_pri_ack              = g_ch[1].pri_ack_q;
   assign f2h_dma_req0_dma_req    = g_ch[0].dma_req_q;
   assign f2h_dma_req0_dma_single = g_ch[0].dma_single_q;
   assign f2h_dma_req1_dma_req    = g_ch[1].dma_req_q;
   assign f2h_dma_req1_dma_single = g_ch[1].dma_single_q;

`ifdef FIFO_DMA_REQ_BRIDGE_STATS_EN
   assign rx_xfer_cnt = g_ch[0].xfer_cnt;
   assign tx_xfer_cnt = g_ch[1].xfer_cnt;
`else
   localparam int unsigned unused_cnt_w = CNT_W;
`endif

endmodule
